// File: rtl/ce_gate_fifo.sv
// Gated Send/Ack FIFO: each packet carries the gate latch value at acceptance;
// closed packets are dropped (MODE=0) or held until released (MODE=1).
module ce_gate_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter bit          MODE  = 1'b0,
  parameter int unsigned CNTW  = 16
) (
  input  logic                     CP,
  input  logic                     MR_n,
  input  logic                     send_in,
  output logic                     ack_out,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     exb,
  output logic                     send_out,
  input  logic                     ack_in,
  output logic [WIDTH-1:0]         data_out,
  input  logic                     release_i,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNTW-1:0]          drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] flag_q;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            dl_q, dl_d;
  logic [CNTW-1:0] drop_q, drop_d;

  logic empty_c, full_c, head_flag_c;
  logic push_c, send_c, drop_c, rel_c, pop_c;

  // Handshake decode; the head is either offered, dropped, or blocked.
  assign empty_c     = (count_q == '0);
  assign full_c      = (count_q == CW'(DEPTH));
  assign head_flag_c = flag_q[rd_ptr_q];
  assign push_c      = send_in & ~full_c;
  assign send_c      = ~empty_c & head_flag_c;
  assign drop_c      = (MODE == 1'b0) & ~empty_c & ~head_flag_c;
  assign rel_c       = (MODE == 1'b1) & ~empty_c & ~head_flag_c & release_i;
  assign pop_c       = (send_c & ack_in) | drop_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dl_d     = dl_q;
    drop_d   = drop_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      dl_d     = exb;
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop_c && (drop_q != {CNTW{1'b1}})) begin
      drop_d = drop_q + CNTW'(1);
    end
  end

  always_ff @(posedge CP) begin
    if (!MR_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dl_q     <= 1'b1;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dl_q     <= dl_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: count=0 makes every slot dead.
  always_ff @(posedge CP) begin
    if (push_c) begin
      data_q[wr_ptr_q] <= data_in;
      flag_q[wr_ptr_q] <= dl_q;
    end
    if (rel_c) begin
      flag_q[rd_ptr_q] <= 1'b1;
    end
  end

  assign ack_out  = ~full_c;
  assign send_out = send_c;
  assign data_out = data_q[rd_ptr_q];
  assign count    = count_q;
  assign drop_cnt = drop_q;

endmodule
